// File: rtl/uart_rx_pkg.sv
// Shared types and widths for the UART receiver.
package uart_rx_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = 3;

  // Receiver FSM states, 3-bit encoding
  typedef enum logic [2:0] {
    s_IDLE         = 3'd0,
    s_RX_START_BIT = 3'd1,
    s_RX_DATA_BITS = 3'd2,
    s_RX_STOP_BIT  = 3'd3,
    s_CLEANUP      = 3'd4
  } state_t;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received byte and status out.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic              rx_serial;
  logic              rx_dv;
  logic [BYTE_W-1:0] rx_byte;
  logic              rx_frame_err;
  logic              rx_busy;

  // Driver of the serial line, consumer of the decoded results
  modport master (
    output rx_serial,
    input  rx_dv,
    input  rx_byte,
    input  rx_frame_err,
    input  rx_busy
  );

  // The receiver itself
  modport slave (
    input  rx_serial,
    output rx_dv,
    output rx_byte,
    output rx_frame_err,
    output rx_busy
  );

endinterface : uart_rx_if

// File: rtl/uart_rx_clk_counter.sv
// Bit-timing counter: clear, increment, and compare against a terminal value.
module uart_rx_clk_counter
  import uart_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic             at_term_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_term_c = (cnt_q == term);

endmodule : uart_rx_clk_counter

// File: rtl/uart_rx.sv
// 8N1 UART receiver, samples each bit at its midpoint.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic              i_Clock,
  input  logic              i_Enable,
  input  logic              i_RX_Serial,
  output logic              o_RX_DV,
  output logic [BYTE_W-1:0] o_RX_Byte,
  output logic              o_RX_Frame_Err,
  output logic              o_RX_Busy
);

  localparam int unsigned HALF_TERM = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned FULL_TERM = CLKS_PER_BIT - 1;

  state_t            state_q,  state_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic [BYTE_W-1:0] shift_q,  shift_d;
  logic [BYTE_W-1:0] byte_q,   byte_d;
  logic              dv_q,     dv_d;
  logic              err_q,    err_d;
  logic              meta_q,   meta_d;
  logic              rx_s_q,   rx_s_d;

  logic              cnt_clr;
  logic              cnt_inc;
  logic [CNT_W-1:0]  cnt_term;
  logic              at_term_c;

  uart_rx_clk_counter u_clk_counter (
    .clk       (i_Clock),
    .rst_n     (i_Enable),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .term      (cnt_term),
    .at_term_c (at_term_c)
  );

  // Next-state, datapath and output pulse decode
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    err_d    = 1'b0;
    meta_d   = i_RX_Serial;
    rx_s_d   = meta_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    cnt_term = CNT_W'(FULL_TERM);

    case (state_q)
      s_IDLE: begin
        cnt_clr = 1'b1;
        idx_d   = '0;
        if (!rx_s_q) begin
          state_d = s_RX_START_BIT;
        end
      end

      s_RX_START_BIT: begin
        cnt_term = CNT_W'(HALF_TERM);
        if (at_term_c) begin
          cnt_clr = 1'b1;
          // A line that is high again mid-start-bit was only a glitch
          state_d = rx_s_q ? s_IDLE : s_RX_DATA_BITS;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      s_RX_DATA_BITS: begin
        if (at_term_c) begin
          cnt_clr         = 1'b1;
          shift_d[idx_q]  = rx_s_q;
          if (idx_q == IDX_W'(7)) begin
            idx_d   = '0;
            state_d = s_RX_STOP_BIT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end

      s_RX_STOP_BIT: begin
        if (at_term_c) begin
          cnt_clr = 1'b1;
          if (rx_s_q) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          state_d = s_CLEANUP;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      s_CLEANUP: begin
        cnt_clr = 1'b1;
        state_d = s_IDLE;
      end

      default: begin
        cnt_clr = 1'b1;
        idx_d   = '0;
        state_d = s_IDLE;
      end
    endcase
  end

  // State, datapath and synchronizer registers
  always_ff @(posedge i_Clock) begin
    if (!i_Enable) begin
      state_q <= s_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      meta_q  <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      meta_q  <= meta_d;
      rx_s_q  <= rx_s_d;
    end
  end

  assign o_RX_DV        = dv_q;
  assign o_RX_Byte      = byte_q;
  assign o_RX_Frame_Err = err_q;
  assign o_RX_Busy      = (state_q != s_IDLE);

endmodule : uart_rx
